// File: rtl/sprite_pkg.sv
// Shared types for the sprite motion generator.
// State encoding, direction encoding, speed width and limit helper.
package sprite_pkg;

    localparam int SPD_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        CALC_X,
        CALC_Y,
        COMMIT
    } state_t;

    // One bit per axis: 0 moves toward larger coordinates.
    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

    // Largest top-left coordinate that keeps the scaled sprite on screen.
    function automatic int span_limit(int res, int dim, int scale);
        return res - (dim << scale);
    endfunction

endpackage

// File: rtl/sprite_motion_if.sv
// Bundle between the frame timing source and the sprite position block.
// master: drives frame/en/speed, reads sprx/spry/bounce_x/bounce_y/busy.
// slave:  the reverse (the sprite_motion block).
interface sprite_motion_if
    import sprite_pkg::*;
#(
    parameter int CORDW = 16
);
    logic                     frame;
    logic                     en;
    logic [SPD_W-1:0]         speed;
    logic signed [CORDW-1:0]  sprx;
    logic signed [CORDW-1:0]  spry;
    logic                     bounce_x;
    logic                     bounce_y;
    logic                     busy;

    modport master (
        output frame, en, speed,
        input  sprx, spry, bounce_x, bounce_y, busy
    );

    modport slave (
        input  frame, en, speed,
        output sprx, spry, bounce_x, bounce_y, busy
    );

endinterface

// File: rtl/sprite_axis_step.sv
// One-axis next position / direction / bounce calculation (combinational).
// Ports: pos, dir, spd, limit in; npos, ndir, bounce out.
module sprite_axis_step
    import sprite_pkg::*;
#(
    parameter int CORDW = 16
) (
    input  logic signed [CORDW-1:0] pos,
    input  dir_t                    dir,
    input  logic [SPD_W-1:0]        spd,
    input  logic signed [CORDW-1:0] limit,
    output logic signed [CORDW-1:0] npos,
    output dir_t                    ndir,
    output logic                    bounce
);

    // One extra bit so pos +/- spd can never wrap.
    logic signed [CORDW:0] pos_e;
    logic signed [CORDW:0] spd_e;
    logic signed [CORDW:0] lim_e;
    logic signed [CORDW:0] sum;
    logic signed [CORDW:0] dif;
    logic signed [CORDW:0] raw;
    logic                  hit;

    assign pos_e = {pos[CORDW-1], pos};
    assign lim_e = {limit[CORDW-1], limit};
    assign spd_e = signed'({{(CORDW + 1 - SPD_W){1'b0}}, spd});
    assign sum   = pos_e + spd_e;
    assign dif   = pos_e - spd_e;

    always_comb begin
        hit = 1'b0;
        raw = pos_e;
        if (spd != '0) begin
            if (dir == DIR_POS) begin
                hit = (sum >= lim_e);
                raw = sum;
            end else begin
                hit = (pos_e <= spd_e);
                raw = dif;
            end
        end
    end

    // A non-bouncing move that still lands outside [0, limit] (an
    // out-of-range start moving inward) is pulled back to the range.
    always_comb begin
        bounce = hit;
        ndir   = hit ? dir_t'(~dir) : dir;
        if (hit) begin
            npos = (dir == DIR_POS) ? limit : '0;
        end else if (spd == '0) begin
            npos = pos;
        end else if (raw > lim_e) begin
            npos = limit;
        end else if (raw[CORDW]) begin
            npos = '0;
        end else begin
            npos = raw[CORDW-1:0];
        end
    end

endmodule

// File: rtl/sprite_motion.sv
// Sprite position generator: once per divided frame, steps x then y,
// reflects off screen edges and commits both coordinates on one edge.
// Ports: clk, rst (sync, active-high), bus (sprite_motion_if.slave).
module sprite_motion
    import sprite_pkg::*;
#(
    parameter int CORDW      = 16,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int SPR_WIDTH  = 8,
    parameter int SPR_HEIGHT = 8,
    parameter int SPR_SCALE  = 0,
    parameter int X_START    = 0,
    parameter int Y_START    = 0,
    parameter int FRAME_DIV  = 0
) (
    input  logic           clk,
    input  logic           rst,
    sprite_motion_if.slave bus
);

    localparam logic signed [CORDW-1:0] XMAX =
        CORDW'(span_limit(H_RES, SPR_WIDTH, SPR_SCALE));
    localparam logic signed [CORDW-1:0] YMAX =
        CORDW'(span_limit(V_RES, SPR_HEIGHT, SPR_SCALE));
    localparam logic signed [CORDW-1:0] X0 = CORDW'(X_START);
    localparam logic signed [CORDW-1:0] Y0 = CORDW'(Y_START);
    localparam bit NODIV = (FRAME_DIV == 0);
    localparam int DIV_W = NODIV ? 1 : FRAME_DIV;

    state_t state;
    state_t state_nx;

    logic                    do_x;
    logic                    do_y;
    logic                    do_cm;
    logic                    accept;
    logic                    start;
    logic [DIV_W-1:0]        div;
    logic [SPD_W-1:0]        spd_r;
    logic signed [CORDW-1:0] x;
    logic signed [CORDW-1:0] y;
    dir_t                    dir_x;
    dir_t                    dir_y;
    logic signed [CORDW-1:0] nx;
    logic signed [CORDW-1:0] ny;
    logic                    bx;
    logic                    by;
    logic                    bnc_x;
    logic                    bnc_y;
    logic                    busy_r;

    logic signed [CORDW-1:0] a_pos;
    logic signed [CORDW-1:0] a_lim;
    dir_t                    a_dir;
    logic signed [CORDW-1:0] s_pos;
    dir_t                    s_dir;
    logic                    s_bnc;

    // busy lags the FSM by one cycle, so a frame arriving in the cycle
    // right after COMMIT is still refused.
    assign accept = (state == IDLE) && !busy_r && bus.en && bus.frame;
    assign start  = accept && (NODIV || (&div));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = CALC_X;
            CALC_X:  state_nx = CALC_Y;
            CALC_Y:  state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        do_x  = 1'b0;
        do_y  = 1'b0;
        do_cm = 1'b0;
        unique case (state)
            IDLE:    ;
            CALC_X:  do_x  = 1'b1;
            CALC_Y:  do_y  = 1'b1;
            COMMIT:  do_cm = 1'b1;
        endcase
    end

    // Single step unit shared between the two calculation cycles.
    assign a_pos = do_y ? y     : x;
    assign a_dir = do_y ? dir_y : dir_x;
    assign a_lim = do_y ? YMAX  : XMAX;

    sprite_axis_step #(
        .CORDW (CORDW)
    ) u_step (
        .pos    (a_pos),
        .dir    (a_dir),
        .spd    (spd_r),
        .limit  (a_lim),
        .npos   (s_pos),
        .ndir   (s_dir),
        .bounce (s_bnc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            x      <= X0;
            y      <= Y0;
            dir_x  <= DIR_POS;
            dir_y  <= DIR_POS;
            nx     <= '0;
            ny     <= '0;
            bx     <= 1'b0;
            by     <= 1'b0;
            bnc_x  <= 1'b0;
            bnc_y  <= 1'b0;
            busy_r <= 1'b0;
            div    <= '0;
            spd_r  <= '0;
        end else begin
            busy_r <= (state != IDLE);
            bnc_x  <= 1'b0;
            bnc_y  <= 1'b0;
            if (accept) begin
                div <= NODIV ? '0 : div + 1'b1;
            end
            if (start) begin
                spd_r <= bus.speed;
            end
            if (do_x) begin
                nx    <= s_pos;
                dir_x <= s_dir;
                bx    <= s_bnc;
            end
            if (do_y) begin
                ny    <= s_pos;
                dir_y <= s_dir;
                by    <= s_bnc;
            end
            if (do_cm) begin
                x     <= nx;
                y     <= ny;
                bnc_x <= bx;
                bnc_y <= by;
            end
        end
    end

    assign bus.sprx     = x;
    assign bus.spry     = y;
    assign bus.bounce_x = bnc_x;
    assign bus.bounce_y = bnc_y;
    assign bus.busy     = busy_r;

endmodule

// File: doc/sprite_motion.md
Name: sprite_motion

Overview:
- Position generator directly upstream of the sprite renderer: drives its sprx/spry inputs.
- Once per (divided) frame: advances the sprite by a runtime speed, reflects off screen edges, updates both coordinates atomically.
- Triggered by the display's frame-start pulse, so coordinates change only during blanking, never mid-line.

Parameters:
- CORDW, 16, signed coordinate width (bits)
- H_RES, 640, horizontal active pixels
- V_RES, 480, vertical active lines
- SPR_WIDTH, 8, sprite bitmap width (pixels)
- SPR_HEIGHT, 8, sprite bitmap height (pixels)
- SPR_SCALE, 0, scale shift; on-screen size = dimension << SPR_SCALE
- X_START, 0, reset x position
- Y_START, 0, reset y position
- FRAME_DIV, 0, update every 2**FRAME_DIV accepted frames

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- frame  in  1  one-cycle pulse at start of vertical blanking
- en  in  1  motion enable
- speed  in  4  pixels moved per update, unsigned
- sprx  out  CORDW  sprite x, signed
- spry  out  CORDW  sprite y, signed
- bounce_x  out  1  one-cycle pulse: x direction reversed this update
- bounce_y  out  1  one-cycle pulse: y direction reversed this update
- busy  out  1  update in progress

Behaviour:
- Reset: sprx=X_START, spry=Y_START, dir_x=dir_y=+1, bounce_x=bounce_y=0, busy=0, divider=0, state IDLE. rst overrides everything, including a frame pulse in the same cycle.
- Limits: XMAX=H_RES-(SPR_WIDTH<<SPR_SCALE), YMAX=V_RES-(SPR_HEIGHT<<SPR_SCALE). All compares signed at CORDW bits; speed is zero-extended.
- Frame acceptance: only in IDLE with en=1. On an accepted frame the divider increments (wraps at 2**FRAME_DIV). An update starts only when the divider was all-ones before the increment; with FRAME_DIV=0, every accepted frame starts one.
- Ignored frames: frame while busy, or with en=0, is ignored and the divider does not advance.
- speed is sampled into a working register on the starting frame.
- State machine:
  - IDLE -> CALC_X on a starting frame.
  - CALC_X -> CALC_Y -> COMMIT -> IDLE, one cycle each.
- CALC_X, dir_x=+1:
  - If x+spd >= XMAX: nx=XMAX, dir_x<=-1, flag bx.
  - Else nx=x+spd.
- CALC_X, dir_x=-1:
  - If x <= spd: nx=0, dir_x<=+1, flag bx.
  - Else nx=x-spd.
- CALC_Y: identical rule on y with YMAX and dir_y.
- speed=0: position unchanged and no bounce, including when sitting exactly on a limit.
- Out-of-range start (x>XMAX or x<0): clamped to the limit on the first update, and bounces if moving outward.
- COMMIT: sprx<=nx and spry<=ny in the same edge (atomic); bounce_x<=bx and bounce_y<=by.
- Timing (frame sampled at edge N):
  - busy=1 after edges N+1..N+3, 0 after N+4.
  - New sprx/spry visible after edge N+3.
  - Bounce pulses high exactly one cycle, from edge N+3 to N+4; simultaneous corner bounce raises both pulses together.
- Reset mid-update: working values are discarded, no pulse is emitted, outputs return to reset values.

Decomposition:
- Shared package sprite_pkg:
  - state enum {IDLE, CALC_X, CALC_Y, COMMIT}
  - direction encoding (1 bit, 0=+1)
  - speed width constant SPD_W=4
- One natural sub-module, sprite_axis_step: combinational next-position/next-direction/bounce calculation for one axis, taking pos, dir, spd, limit. Instantiated once and time-shared across CALC_X/CALC_Y, or twice; implementer's choice, results identical.

Test Plan:
- Right-edge bounce: H_RES=640, SPR_WIDTH=8, x=630, dir +1, speed=4, frame -> sprx=632, bounce_x pulse one cycle; next frame -> sprx=628, no pulse.
- Left-edge bounce: x=3, dir -1, speed=4, frame -> sprx=0, bounce_x=1, dir +1; next frame -> sprx=4.
- Corner: x=630, y=470 (YMAX=472), both dir +1, speed=2 -> sprx=632, spry=472, bounce_x and bounce_y high in the same cycle.
- Latency/atomicity: frame at cycle 10 -> busy high cycles 11-13, sprx and spry change together at cycle 13; frame at cycle 12 is ignored.
- Divider/enable: FRAME_DIV=2, speed=1, 8 frames -> position advances at frames 4 and 8 only; with en=0, 8 frames -> no change and the divider is unchanged.
- Reset mid-update: assert rst in CALC_Y during a bounce update -> sprx=X_START, spry=Y_START, no bounce pulse, busy=0 next cycle.
